insn_fetch_unit: RTL and testbench

//  Read-side initiator on the memory port. Fetches instruction words in bursts starting at START_ADDR,

---
 rtl/insn_fetch_unit.sv | 182 ++++++++++++++++++
 tb/tb_insn_fetch_unit.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/insn_fetch_unit.sv
// Purpose: burst instruction fetcher feeding a prefetch FIFO, with branch redirect and flush.
// Latency: a request is accepted at cycle A; the first instruction is visible to decode at A+2.
// Backpressure: stall holds the FIFO head; requests are issued only while the FIFO has room for a burst.
// Optional: define FETCH_PERF_CNT_EN to add the perf_words / perf_stall counters.
module insn_fetch_unit #(
    parameter int                      DATA_WIDTH    = 32,
    parameter int                      ADDRESS_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0] START_ADDR   = 32'h80020000,
    parameter logic [1:0]              BURST_SIZE    = 2'b01,
    parameter int                      FIFO_DEPTH    = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [1:0]               mem_access_size,
    output logic                     mem_rw,
    output logic                     mem_enable,
    input  logic                     mem_busy,
    input  logic [DATA_WIDTH-1:0]    mem_data_out,
    output logic [DATA_WIDTH-1:0]    insn,
    output logic [ADDRESS_WIDTH-1:0] pc_out,
    output logic                     insn_valid,
    input  logic                     stall,
    input  logic                     branch_taken,
    input  logic [ADDRESS_WIDTH-1:0] branch_target
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]              perf_words,
    output logic [31:0]              perf_stall
`endif
);

    localparam int BW = (BURST_SIZE == 2'b00) ? 1 :
                        (BURST_SIZE == 2'b01) ? 4 :
                        (BURST_SIZE == 2'b10) ? 8 : 16;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int KW = 5;

    typedef enum logic [1:0] {S_REQ, S_RECV, S_DRAIN} state_t;

    state_t                   state;
    logic [ADDRESS_WIDTH-1:0] fetch_pc;
    logic [ADDRESS_WIDTH-1:0] base_pc;
    logic [KW-1:0]            beat_idx;
    logic [KW-1:0]            discard;

    logic [DATA_WIDTH-1:0]    insn_q [FIFO_DEPTH];
    logic [ADDRESS_WIDTH-1:0] pc_q   [FIFO_DEPTH];
    logic [PW-1:0]            rd_ptr;
    logic [PW-1:0]            wr_ptr;
    logic [CW-1:0]            count;

    logic                     accept;
    logic                     push;
    logic                     pop;
    logic                     space_ok;
    logic [ADDRESS_WIDTH-1:0] beat_pc;
    logic                     unused_tgt_bits;

    // The request address is the fetch PC itself; it cannot move while a request is pending.
    assign mem_address     = fetch_pc;
    assign mem_access_size = BURST_SIZE;
    assign mem_rw          = 1'b1;

    assign accept     = mem_enable && !mem_busy;
    assign push       = (state == S_RECV) && !branch_taken;
    assign insn_valid = (count != '0);
    assign pop        = insn_valid && !stall && !branch_taken;
    assign space_ok   = (count <= CW'(FIFO_DEPTH - BW));
    assign beat_pc    = base_pc + (ADDRESS_WIDTH'(beat_idx) << 2);

    assign insn   = insn_q[rd_ptr];
    assign pc_out = pc_q[rd_ptr];

    assign unused_tgt_bits = ^branch_target[1:0];

    // Fetch sequencer: issue bursts, collect beats, and swallow beats of a killed burst.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_REQ;
            mem_enable <= 1'b0;
            fetch_pc   <= START_ADDR;
            base_pc    <= START_ADDR;
            beat_idx   <= '0;
            discard    <= '0;
        end else if (branch_taken) begin
            fetch_pc   <= {branch_target[ADDRESS_WIDTH-1:2], 2'b00};
            mem_enable <= 1'b0;
            beat_idx   <= '0;
            case (state)
                S_REQ: begin
                    if (accept) begin
                        state   <= S_DRAIN;
                        discard <= KW'(BW);
                    end
                end
                S_RECV: begin
                    // The beat arriving now is dropped; the rest of the burst is still owed.
                    discard <= KW'(BW - 1) - beat_idx;
                    state   <= (beat_idx == KW'(BW - 1)) ? S_REQ : S_DRAIN;
                end
                S_DRAIN: begin
                    discard <= discard - 1'b1;
                    if (discard == KW'(1)) state <= S_REQ;
                end
                default: state <= S_REQ;
            endcase
        end else begin
            case (state)
                S_REQ: begin
                    if (accept) begin
                        state      <= S_RECV;
                        mem_enable <= 1'b0;
                        base_pc    <= fetch_pc;
                        fetch_pc   <= fetch_pc + ADDRESS_WIDTH'(4 * BW);
                        beat_idx   <= '0;
                    end else begin
                        // Once raised, the request stays up until accepted.
                        mem_enable <= mem_enable | space_ok;
                    end
                end
                S_RECV: begin
                    if (beat_idx == KW'(BW - 1)) begin
                        state    <= S_REQ;
                        beat_idx <= '0;
                    end else begin
                        beat_idx <= beat_idx + 1'b1;
                    end
                end
                S_DRAIN: begin
                    discard <= discard - 1'b1;
                    if (discard == KW'(1)) state <= S_REQ;
                end
                default: state <= S_REQ;
            endcase
        end
    end

    // Prefetch FIFO: push beats, pop on decode accept, flush on redirect.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                insn_q[i] <= '0;
                pc_q[i]   <= START_ADDR;
            end
        end else if (branch_taken) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                insn_q[wr_ptr] <= mem_data_out;
                pc_q[wr_ptr]   <= beat_pc;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Free-running performance counters: words fetched and cycles decode held a valid word.
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_words <= '0;
            perf_stall <= '0;
        end else begin
            perf_words <= perf_words + 32'(push);
            perf_stall <= perf_stall + 32'(insn_valid && stall);
        end
    end
`endif

endmodule

// File: tb/tb_insn_fetch_unit.sv
// Directed bench for insn_fetch_unit with a burst memory model and an in-order stream scoreboard.
module tb_insn_fetch_unit;

    localparam logic [31:0] START = 32'h80020000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] mem_address;
    logic [1:0]  mem_access_size;
    logic        mem_rw;
    logic        mem_enable;
    logic        mem_busy = 1'b0;
    logic [31:0] mem_data_out;
    logic [31:0] insn;
    logic [31:0] pc_out;
    logic        insn_valid;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_words;
    logic [31:0] perf_stall;
`endif

    int npass = 0;
    int ntot  = 0;
    int cyc   = 0;

    int          pend;
    int          mk;
    logic [31:0] mbase;
    logic [31:0] acc_addr[$];
    int          acc_cyc[$];

    always #5 clock = ~clock;

    insn_fetch_unit dut (
        .clock          (clock),
        .reset          (reset),
        .mem_address    (mem_address),
        .mem_access_size(mem_access_size),
        .mem_rw         (mem_rw),
        .mem_enable     (mem_enable),
        .mem_busy       (mem_busy),
        .mem_data_out   (mem_data_out),
        .insn           (insn),
        .pc_out         (pc_out),
        .insn_valid     (insn_valid),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_words     (perf_words),
        .perf_stall     (perf_stall)
`endif
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'h5A5A5A5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(posedge clock) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Memory model: 4-word bursts, beat k driven in cycle accept+1+k.
    initial begin
        mem_data_out = '0;
        pend = 0;
        mk = 0;
        mbase = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                pend = 0;
                mem_data_out = '0;
            end else begin
                if (pend > 0) begin
                    mem_data_out = memf(mbase + 32'(mk * 4));
                    mk++;
                    pend--;
                end else begin
                    mem_data_out = 32'hDEADBEEF;
                end
                if (mem_enable && !mem_busy) begin
                    mbase = mem_address;
                    mk = 0;
                    pend = 4;
                    acc_addr.push_back(mem_address);
                    acc_cyc.push_back(cyc);
                end
            end
        end
    end

    // Scoreboard: decode must see a contiguous word stream from reset or the latest redirect.
    initial begin
        logic [31:0] exp_pc;
        logic [31:0] req_pc;
        exp_pc = START;
        req_pc = START;
        forever begin
            @(negedge clock);
            if (reset) begin
                exp_pc = START;
                req_pc = START;
            end else begin
                chk("mem_rw", 32'(mem_rw), 32'd1);
                chk("access_size", 32'(mem_access_size), 32'd1);
                if (mem_enable) chk("req_addr", mem_address, req_pc);
                if (insn_valid) begin
                    chk("head_pc", pc_out, exp_pc);
                    chk("head_insn", insn, memf(exp_pc));
                end
                if (branch_taken) begin
                    exp_pc = {branch_target[31:2], 2'b00};
                    req_pc = {branch_target[31:2], 2'b00};
                end else begin
                    if (insn_valid && !stall) exp_pc = exp_pc + 32'd4;
                    if (mem_enable && !mem_busy) req_pc = req_pc + 32'd16;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input logic st, input logic bz);
        reset = 1'b1;
        stall = st;
        mem_busy = bz;
        branch_taken = 1'b0;
        branch_target = '0;
        tick();
        tick();
        acc_addr.delete();
        acc_cyc.delete();
        reset = 1'b0;
    endtask

    function automatic logic [31:0] qa(input int i);
        return (acc_addr.size() > i) ? acc_addr[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] qc(input int i);
        return (acc_cyc.size() > i) ? 32'(acc_cyc[i]) : 32'hFFFF_FFFF;
    endfunction

    initial begin
        int          fv;
        logic [31:0] fpc;
        logic [31:0] fins;
        int          nv;
        logic [31:0] last_pc;
        logic        en_seen;

        // 1: reset values and first fetch timing
        reset = 1'b1;
        tick();
        tick();
        chk("rst_enable", 32'(mem_enable), 32'd0);
        chk("rst_valid", 32'(insn_valid), 32'd0);
        chk("rst_insn", insn, 32'd0);
        chk("rst_pc", pc_out, START);
        chk("rst_addr", mem_address, START);
        acc_addr.delete();
        acc_cyc.delete();
        reset = 1'b0;
        chk("c0_enable", 32'(mem_enable), 32'd0);
        fv = -1; fpc = '0; fins = '0;
        repeat (12) begin
            if (insn_valid && fv < 0) begin fv = cyc; fpc = pc_out; fins = insn; end
            tick();
        end
        chk("t1_acc_cyc", qc(0), 32'd1);
        chk("t1_acc_addr", qa(0), 32'h80020000);
        chk("t1_vld_cyc", 32'(fv), 32'd3);
        chk("t1_insn", fins, 32'hDA585A5A);
        chk("t1_pc", fpc, 32'h80020000);

        // 2: stall held, FIFO fills to 16 then drains one per cycle
        do_reset(1'b1, 1'b0);
        en_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i >= 20) en_seen = en_seen | mem_enable;
            tick();
        end
        chk("t2_accepts", 32'(acc_cyc.size()), 32'd4);
        chk("t2_late_enable", 32'(en_seen), 32'd0);
        chk("t2_valid", 32'(insn_valid), 32'd1);
        chk("t2_head_pc", pc_out, START);
        stall = 1'b0;
        nv = 0; last_pc = '0;
        repeat (16) begin
            if (insn_valid) begin nv++; last_pc = pc_out; end
            tick();
        end
        chk("t2_drain_valid", 32'(nv), 32'd16);
        chk("t2_pc15", last_pc, 32'h8002003C);

        // 3: memory busy for 5 cycles during the first request
        do_reset(1'b0, 1'b1);
        fv = -1;
        repeat (12) begin
            if (cyc >= 1 && cyc <= 5) begin
                chk("t3_hold_en", 32'(mem_enable), 32'd1);
                chk("t3_hold_addr", mem_address, START);
            end
            if (insn_valid && fv < 0) fv = cyc;
            if (cyc == 6) mem_busy = 1'b0;
            tick();
        end
        chk("t3_acc_cyc", qc(0), 32'd6);
        chk("t3_vld_cyc", 32'(fv), 32'd8);

        // 4: redirect during beat 1 of the first burst
        do_reset(1'b0, 1'b0);
        fv = -1; fpc = '0; fins = '0;
        repeat (16) begin
            if (cyc >= 4 && cyc <= 8) chk("t4_flushed", 32'(insn_valid), 32'd0);
            if (cyc >= 4 && insn_valid && fv < 0) begin fv = cyc; fpc = pc_out; fins = insn; end
            if (cyc == 3) begin branch_taken = 1'b1; branch_target = 32'h80020043; end
            if (cyc == 4) branch_taken = 1'b0;
            tick();
        end
        chk("t4_req_addr", qa(1), 32'h80020040);
        chk("t4_req_cyc", qc(1), 32'd7);
        chk("t4_vld_cyc", 32'(fv), 32'd9);
        chk("t4_pc", fpc, 32'h80020040);
        chk("t4_insn", fins, 32'hDA585A1A);

        // 5: fetch address wraps past the top of the address space
        do_reset(1'b0, 1'b0);
        repeat (24) begin
            if (cyc == 3) begin branch_taken = 1'b1; branch_target = 32'hFFFFFFF0; end
            if (cyc == 4) branch_taken = 1'b0;
            tick();
        end
        chk("t5_req1_addr", qa(1), 32'hFFFFFFF0);
        chk("t5_req2_addr", qa(2), 32'h00000000);
        chk("t5_req2_cyc", qc(2), 32'd13);

        // 6: reset asserted while a burst is being received
        do_reset(1'b0, 1'b0);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        chk("t6_rst_enable", 32'(mem_enable), 32'd0);
        chk("t6_rst_valid", 32'(insn_valid), 32'd0);
        chk("t6_rst_insn", insn, 32'd0);
        chk("t6_rst_pc", pc_out, START);
        chk("t6_rst_addr", mem_address, START);
        acc_addr.delete();
        acc_cyc.delete();
        reset = 1'b0;
        fv = -1; fpc = '0;
        repeat (10) begin
            if (insn_valid && fv < 0) begin fv = cyc; fpc = pc_out; end
            tick();
        end
        chk("t6_acc_cyc", qc(0), 32'd1);
        chk("t6_acc_addr", qa(0), START);
        chk("t6_vld_cyc", 32'(fv), 32'd3);
        chk("t6_pc", fpc, START);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
